// File: rtl/seg7_pkg.sv
// seg7_pkg: the active-low 7-segment code table shared by the display encoder
// and the scan decoder. Both ends use this one table.
//   SEG_0..SEG_F : segment codes {a,b,c,d,e,f,g}, 0 = segment lit
//   SEG_BLANK    : all segments dark
//   NUM_DIGITS   : digits on the multiplexed bus
//   cap_state_t  : capture FSM states of the scan decoder
//   hex_to_seg() : nibble -> segment code
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_WAIT_STABLE = 1'b0,
    ST_CAPTURED    = 1'b1
  } cap_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = SEG_A;
      4'hB:    code = SEG_B;
      4'hC:    code = SEG_C;
      4'hD:    code = SEG_D;
      4'hE:    code = SEG_E;
      default: code = SEG_F;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: display bus (an/seg, active-low) plus the decoded
// results of the scan decoder.
//   master : drives an/seg (display side or stimulus), observes the results
//   slave  : the scan decoder; samples an/seg, drives the results
interface seg7_scan_decoder_if;
  logic [seg7_pkg::NUM_DIGITS-1:0]   an;
  logic [6:0]                        seg;
  logic [4*seg7_pkg::NUM_DIGITS-1:0] hex_word;
  logic [seg7_pkg::NUM_DIGITS-1:0]   digit_valid;
  logic                              word_valid;
  logic                              update;
  logic                              bad_pattern;
  logic                              anode_err;

  modport master (
    output an, seg,
    input  hex_word, digit_valid, word_valid, update, bad_pattern, anode_err
  );

  modport slave (
    input  an, seg,
    output hex_word, digit_valid, word_valid, update, bad_pattern, anode_err
  );
endinterface

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational reverse lookup of the shared segment table.
//   i_seg    : active-low segment code {a..g}
//   o_hit    : code is one of the 16 hex glyphs
//   o_nibble : matching hex value (0 when o_hit is low)
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_hit,
  output logic [3:0] o_nibble
);

  logic [15:0] w_match;

  // Compare against the encoder's own table so the two can never diverge.
  for (genvar gi = 0; gi < 16; gi++) begin : g_match
    assign w_match[gi] = (i_seg == hex_to_seg(4'(gi)));
  end

  // Table entries are distinct, so at most one match bit is set.
  always_comb begin
    o_hit    = |w_match;
    o_nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (w_match[i]) o_nibble = 4'(i);
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors a multiplexed, active-low 4-digit 7-segment bus
// and recovers the displayed hex digits with per-digit validity.
//   clk, reset : clock (rising edge) and synchronous active-high reset
//   bus        : slave modport; an/seg in, hex_word/digit_valid/word_valid,
//                update/bad_pattern/anode_err pulses out
// Parameters:
//   STABLE_CYC  : cycles {an,seg} must hold before capture (>=1)
//   TIMEOUT_CYC : cycles without refresh before a digit goes invalid (>=2)
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_decoder_if.slave bus
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT_CYC - 1);

  // Two-flop synchronizer; stage 2 is the s_an/s_seg view used everywhere.
  logic [NUM_DIGITS-1:0] r_an_s1, r_an_s2;
  logic [6:0]            r_seg_s1, r_seg_s2;

  logic [STAB_W-1:0] r_stab_cnt;
  cap_state_t        r_state, w_state_next;
  logic              w_change;
  logic              w_capture;

  logic                  w_hit;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_an_low;
  logic                  w_an_one;
  logic                  w_an_multi;

  logic [3:0]            r_nibble [NUM_DIGITS];
  logic                  r_valid  [NUM_DIGITS];
  logic [TMR_W-1:0]      r_timer  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_digit_upd;
  logic [NUM_DIGITS-1:0] w_valid_vec;
  logic [4*NUM_DIGITS-1:0] w_hex_word;

  logic r_update, r_bad_pattern, r_anode_err;

  // Stage 1 differing from stage 2 means s_an/s_seg changes on this edge.
  assign w_change = {r_an_s1, r_seg_s1} != {r_an_s2, r_seg_s2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_s1    <= '0;
      r_an_s2    <= '0;
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_stab_cnt <= '0;
      r_state    <= ST_WAIT_STABLE;
    end else begin
      r_an_s1  <= bus.an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= bus.seg;
      r_seg_s2 <= r_seg_s1;
      r_state  <= w_state_next;
      if (w_change) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  // One capture per dwell. A change on the capture edge itself still lets the
  // capture through (the old value was stable) and re-arms for the new dwell.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_WAIT_STABLE: begin
        if (r_stab_cnt == STAB_MAX) begin
          w_capture    = 1'b1;
          w_state_next = ST_CAPTURED;
        end
      end
      ST_CAPTURED: begin
        w_state_next = ST_CAPTURED;
      end
    endcase
    if (w_change) w_state_next = ST_WAIT_STABLE;
  end

  seg7_to_hex u_seg7_to_hex (
    .i_seg    (r_seg_s2),
    .o_hit    (w_hit),
    .o_nibble (w_nibble)
  );

  // x & (x-1) clears the lowest set bit: zero result means exactly one low anode.
  assign w_an_low   = ~r_an_s2;
  assign w_an_one   = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);
  assign w_an_multi = (w_an_low != '0) && !w_an_one;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic w_sel, w_cap_ok, w_cap_bad, w_expired;

    assign w_sel     = w_capture && w_an_one && !r_an_s2[gi];
    assign w_cap_ok  = w_sel && w_hit;
    assign w_cap_bad = w_sel && !w_hit;
    assign w_expired = (r_timer[gi] == TMR_MAX);

    assign w_digit_upd[gi] = w_cap_ok && (!r_valid[gi] || (r_nibble[gi] != w_nibble));

    // A good capture outranks an expiry landing on the same edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_nibble[gi] <= 4'h0;
        r_valid[gi]  <= 1'b0;
        r_timer[gi]  <= '0;
      end else if (w_cap_ok) begin
        r_nibble[gi] <= w_nibble;
        r_valid[gi]  <= 1'b1;
        r_timer[gi]  <= '0;
      end else begin
        if (!w_expired) r_timer[gi] <= r_timer[gi] + 1'b1;
        if (w_cap_bad || w_expired) r_valid[gi] <= 1'b0;
      end
    end

    assign w_hex_word[4*gi +: 4] = r_nibble[gi];
    assign w_valid_vec[gi]       = r_valid[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_update      <= 1'b0;
      r_bad_pattern <= 1'b0;
      r_anode_err   <= 1'b0;
    end else begin
      r_update      <= |w_digit_upd;
      r_bad_pattern <= w_capture && w_an_one && !w_hit;
      r_anode_err   <= w_capture && w_an_multi;
    end
  end

  assign bus.hex_word    = w_hex_word;
  assign bus.digit_valid = w_valid_vec;
  assign bus.word_valid  = &w_valid_vec;
  assign bus.update      = r_update;
  assign bus.bad_pattern = r_bad_pattern;
  assign bus.anode_err   = r_anode_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed scenarios followed by random
// dwells, every cycle compared against a reference model of the display rules.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_decoder_if dif ();

  seg7_scan_decoder #(
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hex glyph table written out independently of the design package.
  logic [6:0] code_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (code_tab[i] == s) return i;
    return -1;
  endfunction

  // Reference model. The logic sees the pins two edges late (zeros right
  // after reset). A value is captured exactly STABLE edges after the last
  // disturbance (a change of the delayed value, or reset), once per dwell.
  int         k = 0;
  int         last_break = 0;
  logic [10:0] seen_m1 = '0, seen_m2 = '0;
  logic [3:0] m_nib   [4];
  bit         m_val   [4];
  int         m_start [4];
  bit         m_upd, m_bad, m_aerr;
  int         upd_cnt = 0, bad_cnt = 0, aerr_cnt = 0;

  task automatic model_edge(input logic r, input logic [10:0] p);
    logic [3:0] an_v;
    int nlow, d, idx;
    m_upd = 0; m_bad = 0; m_aerr = 0;
    if (r) begin
      seen_m1 = '0; seen_m2 = '0; last_break = k;
      for (int i = 0; i < 4; i++) begin
        m_nib[i] = 4'h0; m_val[i] = 0; m_start[i] = k;
      end
    end else begin
      d = -1; idx = -1;
      if (k - last_break == STABLE) begin
        an_v = seen_m2[10:7];
        nlow = $countones(~an_v);
        if (nlow >= 2) m_aerr = 1;
        else if (nlow == 1) begin
          for (int i = 0; i < 4; i++) if (!an_v[i]) d = i;
          idx = lookup(seen_m2[6:0]);
          if (idx < 0) begin
            m_bad = 1; m_val[d] = 0; d = -1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (i == d) begin
          if (!m_val[i] || m_nib[i] != 4'(idx)) m_upd = 1;
          m_nib[i] = 4'(idx); m_val[i] = 1; m_start[i] = k;
        end else if (k - m_start[i] >= TMO) begin
          m_val[i] = 0;
        end
      end
      if (seen_m1 != seen_m2) last_break = k;
      seen_m2 = seen_m1;
      seen_m1 = p;
    end
  endtask

  task automatic tick();
    logic r;
    logic [10:0] p;
    logic [3:0] vv;
    r = reset;
    p = {dif.an, dif.seg};
    @(posedge clk);
    #1;
    model_edge(r, p);
    vv = {4'(m_val[3]), 4'(m_val[2]), 4'(m_val[1]), 4'(m_val[0])} == 16'h0 ? 4'h0 :
         {m_val[3], m_val[2], m_val[1], m_val[0]};
    check($sformatf("hex@%0d", k),   dif.hex_word, {m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
    check($sformatf("valid@%0d", k), dif.digit_valid, vv);
    check($sformatf("word@%0d", k),  dif.word_valid, &vv);
    check($sformatf("upd@%0d", k),   dif.update, m_upd);
    check($sformatf("bad@%0d", k),   dif.bad_pattern, m_bad);
    check($sformatf("aerr@%0d", k),  dif.anode_err, m_aerr);
    if (dif.update) upd_cnt++;
    if (dif.bad_pattern) bad_cnt++;
    if (dif.anode_err) aerr_cnt++;
    k++;
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
    dif.an  = an;
    dif.seg = seg;
    $display("dwell cyc=%0d an=%b seg=%b len=%0d", k, an, seg, n);
    repeat (n) tick();
  endtask

  initial begin
    int vals [4];
    int n, sel;
    logic [3:0] an;
    logic [6:0] seg;

    // 1: reset held two cycles
    dif.an = 4'hF; dif.seg = 7'h7F; reset = 1'b1;
    tick(); tick();
    check("rst_hex", dif.hex_word, 16'h0000);
    check("rst_valid", dif.digit_valid, 4'h0);
    check("rst_pulses", {dif.update, dif.bad_pattern, dif.anode_err}, 3'b000);
    reset = 1'b0;

    // 2: single digit, capture on the 6th edge, one update pulse
    dif.an = 4'b1110; dif.seg = code_tab[2];
    $display("dwell cyc=%0d an=1110 seg=%b len=12", k, code_tab[2]);
    repeat (5) tick();
    check("d2_early_valid", dif.digit_valid, 4'h0);
    tick();
    check("d2_nib0", dif.hex_word[3:0], 4'h2);
    check("d2_valid", dif.digit_valid, 4'b0001);
    check("d2_upd", dif.update, 1'b1);
    upd_cnt = 0;
    repeat (6) tick();
    check("d2_no_reupd", upd_cnt, 0);

    // 3: scan "1A2F" twice; second scan changes nothing
    vals = '{4'hF, 4'h2, 4'hA, 4'h1};
    for (int d = 3; d >= 0; d--) dwell(~(4'b1 << d), code_tab[vals[d]], 7);
    check("scan_word", dif.hex_word, 16'h1A2F);
    check("scan_wvalid", dif.word_valid, 1'b1);
    upd_cnt = 0;
    for (int d = 3; d >= 0; d--) dwell(~(4'b1 << d), code_tab[vals[d]], 7);
    check("scan2_upd", upd_cnt, 0);
    check("scan2_word", dif.hex_word, 16'h1A2F);

    // 4: toggling seg on digit 1 never captures; settled value after 6 edges
    upd_cnt = 0;
    for (int t = 0; t < 5; t++) dwell(4'b1101, code_tab[(t % 2) ? 7 : 3], 2);
    check("tog_upd", upd_cnt, 0);
    check("tog_nib1", dif.hex_word[7:4], 4'h2);
    dwell(4'b1101, code_tab[11], 6);
    check("settle_nib1", dif.hex_word[7:4], 4'hB);

    // 5: unknown glyph, then two anodes low
    bad_cnt = 0; aerr_cnt = 0; upd_cnt = 0;
    dwell(4'b1101, 7'b1111110, 8);
    check("bad_cnt", bad_cnt, 1);
    check("bad_valid1", dif.digit_valid[1], 1'b0);
    check("bad_nib1", dif.hex_word[7:4], 4'hB);
    bad_cnt = 0;
    dwell(4'b1100, code_tab[0], 8);
    check("aerr_cnt", aerr_cnt, 1);
    check("aerr_bad", bad_cnt, 0);
    check("aerr_upd", upd_cnt, 0);

    // 6: refresh digit 3 once, then scan 0..2 only; digit 3 expires
    dwell(4'b0111, code_tab[1], 7);
    n = 0;
    $display("dwell cyc=%0d scan digits 0..2 until digit 3 expires", k);
    while (dif.digit_valid[3] && n < 100) begin
      dif.an  = ~(4'b1 << ((n / 7) % 3));
      dif.seg = code_tab[n / 7 % 16];
      tick();
      n++;
    end
    // capture was on edge 6 of the 7-edge dwell; expiry 32 edges later
    check("tmo_edges", n, TMO - 1);
    check("tmo_wvalid", dif.word_valid, 1'b0);

    // reset in the middle of a dwell
    dwell(4'b1110, code_tab[5], 3);
    reset = 1'b1;
    tick();
    check("mid_rst_hex", dif.hex_word, 16'h0000);
    check("mid_rst_valid", dif.digit_valid, 4'h0);
    check("mid_rst_pulses", {dif.update, dif.bad_pattern, dif.anode_err}, 3'b000);
    reset = 1'b0;
    repeat (5) tick();
    check("post_rst_early", dif.digit_valid[0], 1'b0);
    tick();
    check("post_rst_nib0", dif.hex_word[3:0], 4'h5);
    check("post_rst_valid0", dif.digit_valid[0], 1'b1);

    // random dwells
    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       an = ~(4'b1 << $urandom_range(0, 3));
      else if (sel == 7) an = 4'hF;
      else               an = 4'($urandom);
      if ($urandom_range(0, 4) != 0) seg = code_tab[$urandom_range(0, 15)];
      else                           seg = 7'($urandom);
      n = ($urandom_range(0, 15) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        $display("reset cyc=%0d", k);
        tick();
        reset = 1'b0;
      end
      dwell(an, seg, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
